seq_divider: RTL

Multi-cycle restoring (shift-subtract) unsigned divider, the inverse operation of the team's 2x2 array multiplier.
- Default geometry splits a 4-bit product back into a quotient and a remainder by a 2-bit factor.
- Sits beside the multiplier in the arithmetic library; used by the self-check (multiply then divide) datapath.
- Start/busy/done handshake; one quotient bit resolved per clock.

---
 rtl/seq_divider_pkg.sv | 30 +++
 rtl/seq_divider_div_step.sv | 48 ++++
 rtl/seq_divider.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module : seq_divider_pkg
// Brief  : Shared defaults, state encoding and full-adder helpers for the
//          sequential restoring divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  localparam int DW_DEF = 4;
  localparam int VW_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step: shift in the next
//          dividend bit and trial-subtract the divisor with a full-adder chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import seq_divider_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW:0] w_shift;
  logic [VW:0] w_sub_b;
  logic [VW:0] w_diff;
  logic [VW:0] w_carry;
  logic        unused_msb;

  // After a restore the remainder is below the divisor, so its MSB is clear
  // and the shift cannot lose information.
  assign w_shift    = {rem_in[VW-1:0], bit_in};
  assign unused_msb = rem_in[VW];
  assign w_sub_b    = ~{1'b0, divisor};
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i <= VW; i++) begin : g_fa
      assign w_diff[i] = fa_sum(w_shift[i], w_sub_b[i], w_carry[i]);
      if (i < VW) begin : g_carry
        assign w_carry[i+1] = fa_carry(w_shift[i], w_sub_b[i], w_carry[i]);
      end
    end
  endgenerate

  assign q_bit   = ~w_diff[VW];
  assign rem_out = q_bit ? w_diff : w_shift;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module : seq_divider
// Brief  : Multi-cycle unsigned restoring divider with start/busy/done
//          handshake, one quotient bit per clock and divide-by-zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int            CW      = $clog2(DW + 1);
  localparam logic [CW-1:0] C_STEPS = CW'(DW);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [VW:0]   r_rem;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_dvs;
  logic [VW:0]   w_rem_nx;
  logic          w_qbit;

  div_step #(.VW(VW)) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_q[DW-1]),
    .divisor (r_dvs),
    .rem_out (w_rem_nx),
    .q_bit   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_count == C_STEPS) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      r_count   <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_dvs     <= '0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // A zero divisor preloads the count so RUN lasts a single cycle.
            r_count <= (divisor == '0) ? C_STEPS : '0;
            r_rem   <= '0;
            r_q     <= dividend;
            r_dvs   <= divisor;
          end
        end
        S_RUN: begin
          if (r_count != C_STEPS) begin
            r_rem   <= w_rem_nx;
            r_q     <= {r_q[DW-2:0], w_qbit};
            r_count <= r_count + CW'(1);
          end else if (r_dvs == '0) begin
            quotient  <= '1;
            remainder <= '0;
            dbz       <= 1'b1;
          end else begin
            quotient  <= r_q;
            remainder <= r_rem[VW-1:0];
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
